// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one single-port pixel RAM between VGA scanout and
// two round-robin write requesters. Each framebuffer pixel covers 2x2 screen
// pixels. Scanout owns the RAM port on even visible columns, and writers get
// every other cycle. Pixel data and syncs leave three cycles after the
// coordinates arrive.
module vga_fb_arbiter #(
  parameter int   CNT_WIDTH  = 10,
  parameter int   ADDR_WIDTH = 17,
  parameter int   DATA_WIDTH = 9,
  parameter int   FB_WIDTH   = 320,
  parameter int   FB_HEIGHT  = 240,
  parameter logic SYNC_IDLE  = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [CNT_WIDTH-1:0]  ia_h_coord,
  input  logic [CNT_WIDTH-1:0]  ia_v_coord,
  input  logic                  i_visible,
  input  logic                  i_h_sync,
  input  logic                  i_v_sync,
  input  logic                  i_wr0_valid,
  output logic                  o_wr0_ready,
  input  logic [ADDR_WIDTH-1:0] ia_wr0_addr,
  input  logic [DATA_WIDTH-1:0] ia_wr0_data,
  input  logic                  i_wr1_valid,
  output logic                  o_wr1_ready,
  input  logic [ADDR_WIDTH-1:0] ia_wr1_addr,
  input  logic [DATA_WIDTH-1:0] ia_wr1_data,
  output logic [ADDR_WIDTH-1:0] oa_mem_addr,
  output logic                  o_mem_we,
  output logic [DATA_WIDTH-1:0] oa_mem_wdata,
  input  logic [DATA_WIDTH-1:0] ia_mem_rdata,
  output logic [DATA_WIDTH-1:0] oa_pixel,
  output logic                  o_pixel_valid,
  output logic                  o_h_sync,
  output logic                  o_v_sync,
  output logic                  o_wr_err
);

  // One extra bit so the word count still fits when it equals 2**ADDR_WIDTH.
  localparam logic [ADDR_WIDTH:0] FB_WORDS = (ADDR_WIDTH+1)'(FB_WIDTH * FB_HEIGHT);

  logic                  scan_slot;
  logic [ADDR_WIDTH-1:0] fb_x;
  logic [ADDR_WIDTH-1:0] fb_y;
  logic [ADDR_WIDTH-1:0] scan_addr;
  logic                  grant0;
  logic                  grant1;
  logic                  wr_fire;
  logic                  wr_in_range;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  logic                  rr_q, rr_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  mem_we_q, mem_we_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  wr_err_q, wr_err_d;
  logic [1:0]            scan_dly_q, scan_dly_d;
  logic [DATA_WIDTH-1:0] pixel_q, pixel_d;
  logic [2:0]            vis_dly_q, vis_dly_d;
  logic [2:0]            hs_dly_q, hs_dly_d;
  logic [2:0]            vs_dly_q, vs_dly_d;

  // Screen coordinates halved down to framebuffer coordinates.
  always_comb begin
    fb_x = ADDR_WIDTH'(ia_h_coord >> 1);
    fb_y = ADDR_WIDTH'(ia_v_coord >> 1);
  end

  // Row base address: shift-and-add for the 320-wide case, a multiply otherwise.
  generate
    if (FB_WIDTH == 320) begin : g_addr_shift
      assign scan_addr = (fb_y << 8) + (fb_y << 6) + fb_x;
    end else begin : g_addr_mult
      assign scan_addr = fb_y * ADDR_WIDTH'(FB_WIDTH) + fb_x;
    end
  endgenerate

  // Stage 0: slot decode, round-robin grant, and next RAM port and pipeline values.
  always_comb begin
    scan_slot   = i_visible && !ia_h_coord[0];
    grant0      = i_rst_n && !scan_slot && i_wr0_valid && (!i_wr1_valid || !rr_q);
    grant1      = i_rst_n && !scan_slot && i_wr1_valid && (!i_wr0_valid ||  rr_q);
    wr_fire     = grant0 || grant1;
    wr_addr     = grant1 ? ia_wr1_addr : ia_wr0_addr;
    wr_data     = grant1 ? ia_wr1_data : ia_wr0_data;
    wr_in_range = {1'b0, wr_addr} < FB_WORDS;

    rr_d = rr_q;
    if ((grant0 && !rr_q) || (grant1 && rr_q)) begin
      rr_d = !rr_q;
    end

    mem_addr_d  = mem_addr_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    if (scan_slot) begin
      mem_addr_d = scan_addr;
    end else if (wr_fire && wr_in_range) begin
      mem_addr_d  = wr_addr;
      mem_we_d    = 1'b1;
      mem_wdata_d = wr_data;
    end

    wr_err_d   = wr_err_q || (wr_fire && !wr_in_range);
    scan_dly_d = {scan_dly_q[0], scan_slot};
    pixel_d    = scan_dly_q[1] ? ia_mem_rdata : pixel_q;
    vis_dly_d  = {vis_dly_q[1:0], i_visible};
    hs_dly_d   = {hs_dly_q[1:0], i_h_sync};
    vs_dly_d   = {vs_dly_q[1:0], i_v_sync};
  end

  // All state. The async clear also kills a write sitting in stage 1.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rr_q        <= 1'b0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      wr_err_q    <= 1'b0;
      scan_dly_q  <= '0;
      pixel_q     <= '0;
      vis_dly_q   <= '0;
      hs_dly_q    <= {3{SYNC_IDLE}};
      vs_dly_q    <= {3{SYNC_IDLE}};
    end else begin
      rr_q        <= rr_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      wr_err_q    <= wr_err_d;
      scan_dly_q  <= scan_dly_d;
      pixel_q     <= pixel_d;
      vis_dly_q   <= vis_dly_d;
      hs_dly_q    <= hs_dly_d;
      vs_dly_q    <= vs_dly_d;
    end
  end

  assign o_wr0_ready   = grant0;
  assign o_wr1_ready   = grant1;
  assign oa_mem_addr   = mem_addr_q;
  assign o_mem_we      = mem_we_q;
  assign oa_mem_wdata  = mem_wdata_q;
  assign oa_pixel      = vis_dly_q[2] ? pixel_q : '0;
  assign o_pixel_valid = vis_dly_q[2];
  assign o_h_sync      = hs_dly_q[2];
  assign o_v_sync      = vs_dly_q[2];
  assign o_wr_err      = wr_err_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter: directed bench with a synchronous RAM model. Stimulus
// queues the expected grants, RAM writes, scan addresses and pixels. A
// negedge monitor pops those queues and compares them against what the DUT presents.
module tb_vga_fb_arbiter;

  localparam int FBW    = 320;
  localparam int FBSIZE = 76800;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  h_coord, v_coord;
  logic        visible, h_sync, v_sync;
  logic        wr0_valid, wr0_ready, wr1_valid, wr1_ready;
  logic [16:0] wr0_addr, wr1_addr;
  logic [8:0]  wr0_data, wr1_data;
  logic [16:0] mem_addr;
  logic        mem_we;
  logic [8:0]  mem_wdata, mem_rdata;
  logic [8:0]  pixel;
  logic        pixel_valid, out_h_sync, out_v_sync, wr_err;

  logic [8:0]  ram [0:FBSIZE-1];

  int          n_pass = 0;
  int          n_total = 0;
  int          w0_left, w1_left;
  logic [16:0] w0_a, w1_a;
  logic [8:0]  w0_d, w1_d;
  logic        push_en, ovr_on;

  int          gq[$];
  logic [25:0] wq[$];
  logic [16:0] rq[$];
  logic [8:0]  pq[$];

  logic        rd_flag;
  logic [2:0]  hs_hist, vs_hist;
  logic        g0, g1;

  vga_fb_arbiter dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .ia_h_coord(h_coord), .ia_v_coord(v_coord),
    .i_visible(visible), .i_h_sync(h_sync), .i_v_sync(v_sync),
    .i_wr0_valid(wr0_valid), .o_wr0_ready(wr0_ready),
    .ia_wr0_addr(wr0_addr), .ia_wr0_data(wr0_data),
    .i_wr1_valid(wr1_valid), .o_wr1_ready(wr1_ready),
    .ia_wr1_addr(wr1_addr), .ia_wr1_data(wr1_data),
    .oa_mem_addr(mem_addr), .o_mem_we(mem_we), .oa_mem_wdata(mem_wdata),
    .ia_mem_rdata(mem_rdata),
    .oa_pixel(pixel), .o_pixel_valid(pixel_valid),
    .o_h_sync(out_h_sync), .o_v_sync(out_v_sync), .o_wr_err(wr_err)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] pat(input int a);
    return 9'(a * 37 + 5);
  endfunction

  function automatic logic [8:0] expPix(input int a);
    if (ovr_on && a == 0) return 9'h1C7;
    return pat(a);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  task automatic failNow(input string name, input logic [31:0] act);
    n_total++;
    $display("[TB] FAIL %s: got %0h, required nothing", name, act);
  endtask

  // Drive one pixel-clock of tracker and requester inputs, and queue the expected results.
  task automatic applyStimulus(input logic [9:0] h, input logic [9:0] v,
                               input logic vis, input logic hs, input logic vs);
    int a;
    h_coord = h; v_coord = v; visible = vis; h_sync = hs; v_sync = vs;
    wr0_valid = (w0_left > 0); wr0_addr = w0_a; wr0_data = w0_d;
    wr1_valid = (w1_left > 0); wr1_addr = w1_a; wr1_data = w1_d;
    if (vis) begin
      a = int'(v >> 1) * FBW + int'(h >> 1);
      pq.push_back(expPix(a));
      if (!h[0]) rq.push_back(17'(a));
    end
    @(negedge clk);
    if (wr0_valid && wr0_ready) begin
      if (push_en && w0_a < 17'(FBSIZE)) wq.push_back({w0_a, w0_d});
      w0_left--; w0_a++; w0_d++;
    end
    if (wr1_valid && wr1_ready) begin
      if (push_en && w1_a < 17'(FBSIZE)) wq.push_back({w1_a, w1_d});
      w1_left--; w1_a++; w1_d++;
    end
    @(posedge clk);
    #1;
  endtask

  // Synchronous single-port RAM with one cycle of read latency.
  initial begin
    for (int i = 0; i < FBSIZE; i++) ram[i] = pat(i);
    forever begin
      @(posedge clk);
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  // Remember which cycle issued a scan read, and the sync inputs, as the DUT sampled them.
  always @(posedge clk) begin
    if (!rst_n) begin
      rd_flag <= 1'b0;
      hs_hist <= 3'b111;
      vs_hist <= 3'b111;
    end else begin
      rd_flag <= visible && !h_coord[0];
      hs_hist <= {hs_hist[1:0], h_sync};
      vs_hist <= {vs_hist[1:0], v_sync};
    end
  end

  // Monitor: compare handshakes, the RAM port, pixels and syncs against the queued expectations.
  always @(negedge clk) begin
    if (rst_n) begin
      g0 = wr0_valid && wr0_ready;
      g1 = wr1_valid && wr1_ready;
      if (g0 || g1) begin
        checkOutput("grant_in_free_slot", 32'(visible && !h_coord[0]), 32'd0);
        checkOutput("single_grant", 32'(g0 && g1), 32'd0);
        if (gq.size() == 0) failNow("grant_unexpected", 32'(g1));
        else checkOutput("grant_order", 32'(g1), 32'(gq.pop_front()));
      end
      if (mem_we) begin
        checkOutput("we_during_scan_read", 32'(rd_flag), 32'd0);
        if (wq.size() == 0) failNow("mem_write_unexpected", 32'({mem_addr, mem_wdata}));
        else checkOutput("mem_write", 32'({mem_addr, mem_wdata}), 32'(wq.pop_front()));
      end else if (rd_flag) begin
        if (rq.size() == 0) failNow("scan_read_unexpected", 32'(mem_addr));
        else checkOutput("scan_addr", 32'(mem_addr), 32'(rq.pop_front()));
      end
      if (pixel_valid) begin
        if (pq.size() == 0) failNow("pixel_unexpected", 32'(pixel));
        else checkOutput("pixel", 32'(pixel), 32'(pq.pop_front()));
      end else begin
        checkOutput("pixel_blank", 32'(pixel), 32'd0);
      end
      checkOutput("h_sync_delay", 32'(out_h_sync), 32'(hs_hist[2]));
      checkOutput("v_sync_delay", 32'(out_v_sync), 32'(vs_hist[2]));
    end
  end

  // Watchdog so the run ends even if the DUT wedges.
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence.
  initial begin
    rst_n = 1'b0;
    h_coord = '0; v_coord = '0; visible = 1'b0; h_sync = 1'b0; v_sync = 1'b0;
    wr0_valid = 1'b0; wr1_valid = 1'b0; wr0_addr = '0; wr1_addr = '0;
    wr0_data = '0; wr1_data = '0;
    push_en = 1'b1; ovr_on = 1'b0;
    w0_left = 3; w0_a = 17'd100; w0_d = 9'h011;
    w1_left = 3; w1_a = 17'd200; w1_d = 9'h022;
    #1;

    $display("[TB] reset with both requesters valid");
    for (int i = 0; i < 4; i++) applyStimulus(10'd700, 10'd490, 1'b0, 1'b0, 1'b0);
    checkOutput("rst_wr0_ready", 32'(wr0_ready), 32'd0);
    checkOutput("rst_wr1_ready", 32'(wr1_ready), 32'd0);
    checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
    checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("rst_pixel", 32'(pixel), 32'd0);
    checkOutput("rst_pixel_valid", 32'(pixel_valid), 32'd0);
    checkOutput("rst_h_sync", 32'(out_h_sync), 32'd1);
    checkOutput("rst_v_sync", 32'(out_v_sync), 32'd1);
    checkOutput("rst_wr_err", 32'(wr_err), 32'd0);

    $display("[TB] blanking arbitration");
    gq.push_back(0); gq.push_back(1); gq.push_back(0);
    gq.push_back(1); gq.push_back(0); gq.push_back(1);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) applyStimulus(10'd700, 10'd490, 1'b0, 1'b1, 1'b1);

    $display("[TB] out-of-range write");
    gq.push_back(0);
    w0_left = 1; w0_a = 17'd76800; w0_d = 9'h1AA;
    for (int i = 0; i < 3; i++) applyStimulus(10'd700, 10'd491, 1'b0, 1'b1, 1'b1);
    checkOutput("wr_err_set", 32'(wr_err), 32'd1);

    $display("[TB] scan row v=479");
    for (int h = 0; h < 640; h++)
      applyStimulus(10'(h), 10'd479, 1'b1, 1'(h >> 3), 1'(h >> 5));
    for (int i = 0; i < 6; i++) applyStimulus(10'(640 + i), 10'd479, 1'b0, 1'b1, 1'b1);

    $display("[TB] visible arbitration on row v=477");
    gq.push_back(1); gq.push_back(0); gq.push_back(1);
    gq.push_back(0); gq.push_back(1); gq.push_back(0);
    w0_left = 3; w0_a = 17'd300; w0_d = 9'h040;
    w1_left = 3; w1_a = 17'd400; w1_d = 9'h080;
    for (int h = 0; h < 640; h++)
      applyStimulus(10'(h), 10'd477, 1'b1, 1'(h >> 2), 1'b1);
    for (int i = 0; i < 6; i++) applyStimulus(10'(640 + i), 10'd477, 1'b0, 1'b1, 1'b0);

    $display("[TB] write-read coherence at address 0");
    gq.push_back(1);
    w1_left = 1; w1_a = 17'd0; w1_d = 9'h1C7;
    ovr_on = 1'b1;
    applyStimulus(10'd700, 10'd524, 1'b0, 1'b1, 1'b0);
    for (int h = 0; h < 4; h++) applyStimulus(10'(h), 10'd0, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(10'(700 + i), 10'd0, 1'b0, 1'b0, 1'b1);
    for (int h = 0; h < 4; h++) applyStimulus(10'(h), 10'd1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus(10'(700 + i), 10'd1, 1'b0, 1'b1, 1'b1);

    $display("[TB] reset during a pending write");
    checkOutput("wr_err_sticky", 32'(wr_err), 32'd1);
    gq.push_back(0);
    push_en = 1'b0;
    w0_left = 1; w0_a = 17'd50; w0_d = 9'h055;
    applyStimulus(10'd700, 10'd2, 1'b0, 1'b1, 1'b1);
    checkOutput("we_before_reset", 32'(mem_we), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("we_async_drop", 32'(mem_we), 32'd0);
    for (int i = 0; i < 3; i++) applyStimulus(10'd700, 10'd2, 1'b0, 1'b1, 1'b1);
    checkOutput("ram_unchanged", 32'(ram[50]), 32'(pat(50)));
    checkOutput("wr_err_cleared", 32'(wr_err), 32'd0);
    checkOutput("mem_addr_cleared", 32'(mem_addr), 32'd0);
    push_en = 1'b1;

    $display("[TB] round-robin pointer after reset");
    gq.push_back(0); gq.push_back(1);
    w0_left = 1; w0_a = 17'd600; w0_d = 9'h001;
    w1_left = 1; w1_a = 17'd700; w1_d = 9'h002;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) applyStimulus(10'd700, 10'd3, 1'b0, 1'b1, 1'b1);
    checkOutput("wr_err_after_reset", 32'(wr_err), 32'd0);

    checkOutput("grant_queue_drained", 32'(gq.size()), 32'd0);
    checkOutput("write_queue_drained", 32'(wq.size()), 32'd0);
    checkOutput("read_queue_drained", 32'(rq.size()), 32'd0);
    checkOutput("pixel_queue_drained", 32'(pq.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/vga_fb_arbiter.md
# vga_fb_arbiter

Framebuffer port arbiter between the VGA area tracker and a single-port synchronous pixel RAM. Each 320x240 framebuffer pixel is shown as 2x2 screen pixels at 640x480. Scanout reads take absolute priority on even visible columns. All other cycles are shared round-robin between two write requesters with valid/ready handshakes. Outputs are 9-bit RGB333 pixel data and syncs, delayed to stay aligned with the pixel.

## Interface
- CNT_WIDTH, 10, width of the tracker coordinate inputs
- ADDR_WIDTH, 17, framebuffer address width (76800 words)
- DATA_WIDTH, 9, pixel width, {r[2:0], g[2:0], b[2:0]}
- FB_WIDTH, 320, framebuffer columns (must equal H_VISIBLE/2)
- FB_HEIGHT, 240, framebuffer rows
- SYNC_IDLE, 1, reset/idle level of delayed sync outputs
- i_clk  in  1  pixel clock; all logic on rising edge
- i_rst_n  in  1  asynchronous active-low reset
- ia_h_coord, ia_v_coord  in  CNT_WIDTH  tracker coordinates
- i_visible, i_h_sync, i_v_sync  in  1  tracker outputs
- i_wr0_valid / o_wr0_ready  in/out  1  requester 0 handshake
- ia_wr0_addr  in  ADDR_WIDTH; ia_wr0_data  in  DATA_WIDTH
- i_wr1_valid / o_wr1_ready, ia_wr1_addr, ia_wr1_data: requester 1, same widths
- oa_mem_addr  out  ADDR_WIDTH; o_mem_we  out  1; oa_mem_wdata  out  DATA_WIDTH  RAM port, registered
- ia_mem_rdata  in  DATA_WIDTH  RAM read data, valid the cycle after the address is presented
- oa_pixel  out  DATA_WIDTH  pixel to DAC; zero outside visible
- o_pixel_valid, o_h_sync, o_v_sync  out  1  delayed visible/syncs
- o_wr_err  out  1  sticky: out-of-range write accepted

## Operation
- Scan slot: cycle where i_visible=1 and ia_h_coord[0]=0. The port issues a read at addr = (v>>1)*FB_WIDTH + (h>>1).
  - Compute the address as (y<<8)+(y<<6)+x when FB_WIDTH=320. A generic multiply is allowed otherwise.
- Free slot: every other cycle, including all blanking. At most one write is granted per free slot.
- Arbitration is round-robin with pointer rr (reset 0 = requester 0 preferred).
  - If only one requester is valid, it is granted.
  - If both are valid, requester rr is granted and rr toggles.
  - rr changes only on a grant to the preferred requester.
- o_wrN_ready is combinational: 1 only in a free slot when requester N wins. It may depend on i_wrN_valid.
  - A transfer occurs on valid&&ready.
  - Requesters must hold addr/data while valid and not ready.
- Write with addr >= FB_WIDTH*FB_HEIGHT: accepted (ready=1), o_mem_we stays 0, o_wr_err sets and holds until reset.
- Cycles with no scan read and no write: o_mem_we=0, oa_mem_addr holds its previous value.
- Pixel register loads ia_mem_rdata two cycles after the scan slot. It holds for the following odd column, so each fb pixel spans 2 clocks.
- oa_pixel = pixel register when delayed visible=1, else 0.

## Timing
- Stage 0 (cycle t): slot decode, address compute, grant; ready is combinational here.
- Stage 1 (t+1): oa_mem_addr/o_mem_we/oa_mem_wdata registered.
- Stage 2 (t+2): RAM returns data.
- Stage 3 (t+3): oa_pixel registered.
- Coordinate-to-pixel latency: 3 cycles. i_visible, i_h_sync and i_v_sync pass through a matching 3-stage delay to o_pixel_valid, o_h_sync and o_v_sync.
- A write accepted at t appears on the RAM port at t+1.
  - A scan read of the same address issued at t+1 or later returns the new data.
  - A read issued at t-1 or earlier returns the old data.
- While i_rst_n=0:
  - Both readys = 0.
  - oa_mem_addr=0, o_mem_we=0, oa_mem_wdata=0.
  - oa_pixel=0, o_pixel_valid=0.
  - o_h_sync=o_v_sync=SYNC_IDLE, o_wr_err=0, rr=0, delay lines cleared.
- Reset asserted mid-write: the write in stage 1 is dropped (we forced 0 asynchronously). No handshake completes during reset.
- Back-to-back visible lines: the write bandwidth is 1 per 2 clocks in visible and 1 per clock in blanking. Neither requester starves for more than 3 free slots while both are valid.

## Test plan
- Reset: hold i_rst_n=0 with both valids high. Required: readys 0, o_mem_we 0, oa_pixel 0, syncs = SYNC_IDLE. Release, then free slot → wr0 granted first.
- Scan address: drive h=0..639, v=479 visible with no writers. Required:
  - read addresses at even h equal 239*320+h/2, ending at 76799.
  - oa_pixel at h+3 equals RAM content.
  - each value is held for 2 clocks.
- Arbitration: both valid continuously in blanking. Required: grants alternate wr0, wr1, wr0, …. In visible, grants occur only on odd h and still alternate.
- Write-read coherence: during blanking, write 9'h1C7 to addr 0 via wr1. Next frame, the pixel at h=0/1, v=0/1 equals 9'h1C7 at 3-cycle latency.
- Out of range: wr0 writes addr 76800. Required: ready=1, o_mem_we=0, o_wr_err=1 until reset.
- Reset mid-operation: assert i_rst_n low at the cycle after a write accept. Required: o_mem_we drops immediately, and RAM is unchanged.
